// File: rtl/alu_4bit_pkg.sv
// ---------------------------------------------------------------------------
// alu_4bit_pkg
// Shared definitions for the 4-bit ALU and its two-port arbiter:
//   - opcode encodings OP_ADD .. OP_NOT (110/111 are illegal)
//   - arb_state_t : arbiter FSM states IDLE / EXEC / RESP
//   - alu_rsp_t   : registered response (result, carry, zero, err)
//   - is_illegal_op() : flags the two unused opcodes
// ---------------------------------------------------------------------------
package alu_4bit_pkg;

    localparam int ALU_DATA_W = 4;
    localparam int ALU_OP_W   = 3;

    localparam logic [ALU_OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [ALU_OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [ALU_OP_W-1:0] OP_AND = 3'b010;
    localparam logic [ALU_OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [ALU_OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [ALU_OP_W-1:0] OP_NOT = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] result;
        logic                  carry;
        logic                  zero;
        logic                  err;
    } alu_rsp_t;

    // 110 and 111 are the only codes with both upper bits set.
    function automatic logic is_illegal_op(input logic [ALU_OP_W-1:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/alu_4bit_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_4bit_arbiter_if
// Command and response bundle between two requesters and alu_4bit_arbiter.
//   req_valid[1:0] / req_ready[1:0] : per-port command handshake
//   req0_a/b/op, req1_a/b/op        : per-port operands and opcode
//   rsp_valid[1:0] / rsp_ready[1:0] : one-hot response handshake
//   rsp_result/carry/zero/err       : registered response fields
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface alu_4bit_arbiter_if #(
    parameter int DATA_W = 4,
    parameter int OP_W   = 3
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [OP_W-1:0]   req0_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [OP_W-1:0]   req1_op;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_carry;
    logic              rsp_zero;
    logic              rsp_err;

    modport master (
        output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_4bit.sv
// ---------------------------------------------------------------------------
// alu_4bit
// Combinational 4-bit ALU.
//   A, B     in  4 : operands (B ignored for NOT)
//   Op       in  3 : opcode, see alu_4bit_pkg
//   Result   out 4 : operation result
//   CarryOut out 1 : carry for ADD, borrow for SUB, 0 otherwise
//   ZeroFlag out 1 : Result == 0
// ---------------------------------------------------------------------------
module alu_4bit
    import alu_4bit_pkg::*;
(
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [2:0] Op,
    output logic [3:0] Result,
    output logic       CarryOut,
    output logic       ZeroFlag
);

    // Bit 4 holds the carry (ADD) or the wrapped borrow (SUB, set when A < B).
    logic [4:0] wide;

    always_comb begin
        wide = '0;
        case (Op)
            OP_ADD:  wide = {1'b0, A} + {1'b0, B};
            OP_SUB:  wide = {1'b0, A} - {1'b0, B};
            OP_AND:  wide = {1'b0, A & B};
            OP_OR:   wide = {1'b0, A | B};
            OP_XOR:  wide = {1'b0, A ^ B};
            OP_NOT:  wide = {1'b0, ~A};
            default: wide = '0;
        endcase
    end

    assign Result   = wide[3:0];
    assign CarryOut = wide[4];
    assign ZeroFlag = (wide[3:0] == 4'd0);

endmodule

// File: rtl/alu_rr_arb2.sv
// ---------------------------------------------------------------------------
// alu_rr_arb2
// Pure combinational 2-way arbiter.
//   valid_i[1:0]  in  : per-port request
//   last_grant_i  in  : port that won the previous transaction
//   grant_o[1:0]  out : one-hot grant (zero when nothing is valid)
//   grant_id_o    out : index of the granted port
// Macro ALU_ARB_RR_EN: defined -> round-robin on ties (the port that is not
// last_grant_i wins); undefined -> fixed priority, port 0 wins ties and
// last_grant_i is ignored.
// ---------------------------------------------------------------------------
module alu_rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o,
    output logic       grant_id_o
);

`ifdef ALU_ARB_RR_EN
    always_comb begin
        grant_id_o = 1'b0;
        if (valid_i == 2'b11) begin
            grant_id_o = ~last_grant_i;
        end else begin
            grant_id_o = valid_i[1];
        end
        grant_o = 2'b00;
        if (|valid_i) begin
            grant_o[grant_id_o] = 1'b1;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;

    always_comb begin
        grant_id_o = valid_i[1] & ~valid_i[0];
        grant_o    = 2'b00;
        if (|valid_i) begin
            grant_o[grant_id_o] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/alu_4bit_arbiter.sv
// ---------------------------------------------------------------------------
// alu_4bit_arbiter
// Shares one alu_4bit between two requesters. One transaction in flight:
// IDLE accepts the arbitration winner, EXEC registers the ALU output (or the
// fixed illegal-op response), RESP holds the one-hot response until the
// destination port accepts it.
// Ports:
//   clk   in : clock, rising edge
//   rst_n in : asynchronous active-low reset
//   bus   slave modport of alu_4bit_arbiter_if (command + response bundle)
// Macro ALU_ARB_RR_EN: defined -> round-robin with a last_grant register;
// undefined -> fixed priority to port 0, no last_grant register.
// ---------------------------------------------------------------------------
module alu_4bit_arbiter
    import alu_4bit_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_4bit_arbiter_if.slave bus
);

    arb_state_t        state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              id_q, id_d;
    alu_rsp_t          rsp_q, rsp_d;

    logic [1:0]        grant;
    logic              grant_id;
    logic              last_grant;
    logic [1:0]        req_ready;

    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_zero;

    alu_rr_arb2 u_arb (
        .valid_i      (bus.req_valid),
        .last_grant_i (last_grant),
        .grant_o      (grant),
        .grant_id_o   (grant_id)
    );

    // The ALU only ever sees the latched command, so its inputs are stable
    // through EXEC regardless of what the requesters do after the handshake.
    alu_4bit u_alu (
        .A        (a_q),
        .B        (b_q),
        .Op       (op_q),
        .Result   (alu_result),
        .CarryOut (alu_carry),
        .ZeroFlag (alu_zero)
    );

`ifdef ALU_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if ((state_q == IDLE) && (|bus.req_valid)) begin
            last_grant_d = grant_id;
        end
    end

    // Reset value 1 lets port 0 win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        id_d      = id_q;
        rsp_d     = rsp_q;
        req_ready = 2'b00;
        case (state_q)
            IDLE: begin
                // grant is non-zero exactly when some port is valid, so any
                // valid request is a handshake this cycle.
                req_ready = grant;
                if (|bus.req_valid) begin
                    id_d = grant_id;
                    if (grant_id) begin
                        a_d  = bus.req1_a;
                        b_d  = bus.req1_b;
                        op_d = bus.req1_op;
                    end else begin
                        a_d  = bus.req0_a;
                        b_d  = bus.req0_b;
                        op_d = bus.req0_op;
                    end
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (is_illegal_op(op_q)) begin
                    rsp_d.result = '0;
                    rsp_d.carry  = 1'b0;
                    rsp_d.zero   = 1'b1;
                    rsp_d.err    = 1'b1;
                end else begin
                    rsp_d.result = alu_result;
                    rsp_d.carry  = alu_carry;
                    rsp_d.zero   = alu_zero;
                    rsp_d.err    = 1'b0;
                end
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready[id_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            id_q    <= 1'b0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
            rsp_q   <= rsp_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = (state_q == RESP) ? {id_q, ~id_q} : 2'b00;
    assign bus.rsp_result = rsp_q.result;
    assign bus.rsp_carry  = rsp_q.carry;
    assign bus.rsp_zero   = rsp_q.zero;
    assign bus.rsp_err    = rsp_q.err;

endmodule

// File: tb/tb_alu_4bit_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_4bit_arbiter
// Per-port drivers consume command queues; a negedge monitor predicts the
// arbitration winner and the ALU response from plain arithmetic, queues the
// expectation at each command handshake and compares it when the response
// is presented. Directed cases first, then a randomized phase.
// ---------------------------------------------------------------------------
module tb_alu_4bit_arbiter;
    import alu_4bit_pkg::*;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } cmd_t;

    typedef struct {
        int         port;
        logic [3:0] res;
        logic       c;
        logic       z;
        logic       e;
    } exp_t;

    logic clk;
    logic rst_n;
    logic v0, v1;
    logic [3:0] a0, b0, a1, b1;
    logic [2:0] op0, op1;
    logic [1:0] rrdy;

    cmd_t q0[$];
    cmd_t q1[$];
    exp_t sb[$];

    int checks;
    int errors;
    int cyc;
    int drain_to_cnt;
    int drain_seen;

    // monitor state
    logic       inflight;
    logic       busy;
    logic       resp_open;
    int         hs_cyc;
    int         prev_winner;
    logic [1:0] exp_rdy;
    logic [1:0] hs;
    logic [8:0] held;
    exp_t       cur;

    alu_4bit_arbiter_if #(.DATA_W(4), .OP_W(3)) bus ();

    assign bus.req_valid = {v1, v0};
    assign bus.req0_a    = a0;
    assign bus.req0_b    = b0;
    assign bus.req0_op   = op0;
    assign bus.req1_a    = a1;
    assign bus.req1_b    = b1;
    assign bus.req1_op   = op1;
    assign bus.rsp_ready = rrdy;

    alu_4bit_arbiter #(.DATA_W(4), .OP_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Reference ALU from the opcode table, with integer arithmetic.
    function automatic exp_t model(int port, int a, int b, int op);
        exp_t e;
        int   r;
        e.port = port;
        e.c    = 1'b0;
        e.e    = 1'b0;
        case (op)
            0: begin r = a + b; e.c = (r > 15); end
            1: begin r = a - b; e.c = (a < b); if (r < 0) r = r + 16; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 15 - a;
            default: begin r = 0; e.e = 1'b1; end
        endcase
        r     = r % 16;
        e.res = 4'(r);
        e.z   = (r == 0);
        return e;
    endfunction

    // Expected req_ready for the current request vector.
    function automatic logic [1:0] pick(logic [1:0] v, int last);
        if (v == 2'b11) begin
`ifdef ALU_ARB_RR_EN
            return (last == 0) ? 2'b10 : 2'b01;
`else
            return (last < 0) ? 2'b10 : 2'b01;
`endif
        end
        return v;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.a  = 4'($urandom_range(0, 15));
        c.b  = 4'($urandom_range(0, 15));
        c.op = 3'($urandom_range(0, 7));
        return c;
    endfunction

    // ---------------- port drivers ----------------
    initial begin
        cmd_t c;
        int   n;
        v0 = 1'b0; a0 = '0; b0 = '0; op0 = '0;
        @(posedge clk); #1;
        forever begin
            if (q0.size() != 0 && rst_n) begin
                c = q0.pop_front();
                a0 = c.a; b0 = c.b; op0 = c.op; v0 = 1'b1;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!bus.req_ready[0] && n < 64);
                @(posedge clk); #1;
                v0 = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    initial begin
        cmd_t c;
        int   n;
        v1 = 1'b0; a1 = '0; b1 = '0; op1 = '0;
        @(posedge clk); #1;
        forever begin
            if (q1.size() != 0 && rst_n) begin
                c = q1.pop_front();
                a1 = c.a; b1 = c.b; op1 = c.op; v1 = 1'b1;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!bus.req_ready[1] && n < 64);
                @(posedge clk); #1;
                v1 = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        checks = 0; errors = 0; drain_seen = 0;
        inflight = 1'b0; resp_open = 1'b0; hs_cyc = 0; prev_winner = 1;
        held = '0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs",
                {bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_err},
                32'd0);
            sb.delete();
            inflight    = 1'b0;
            resp_open   = 1'b0;
            prev_winner = 1;
        end else begin
            busy    = inflight;
            exp_rdy = busy ? 2'b00 : pick(bus.req_valid, prev_winner);
            if (busy || bus.req_valid != 2'b00 || bus.req_ready != 2'b00) begin
                chk("req_ready", bus.req_ready, exp_rdy);
            end

            if (bus.rsp_valid != 2'b00) begin
                if (!resp_open) begin
                    chk("rsp_latency", cyc - hs_cyc, 2);
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", bus.rsp_valid, 2'b00);
                    end else begin
                        cur = sb.pop_front();
                        chk("rsp_port",   bus.rsp_valid, (cur.port == 1) ? 2'b10 : 2'b01);
                        chk("rsp_result", bus.rsp_result, cur.res);
                        chk("rsp_carry",  bus.rsp_carry, cur.c);
                        chk("rsp_zero",   bus.rsp_zero, cur.z);
                        chk("rsp_err",    bus.rsp_err, cur.e);
                    end
                    held      = {bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_err};
                    resp_open = 1'b1;
                end else begin
                    chk("rsp_stable",
                        {bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_err}, held);
                end
                if ((bus.rsp_valid & bus.rsp_ready) != 2'b00) begin
                    resp_open = 1'b0;
                    inflight  = 1'b0;
                end
            end else if (resp_open) begin
                chk("rsp_dropped", bus.rsp_valid, held[8:7]);
                resp_open = 1'b0;
                inflight  = 1'b0;
            end else if (busy && (cyc - hs_cyc) >= 2) begin
                if (sb.size() != 0) begin
                    chk("rsp_missing", bus.rsp_valid, (sb[0].port == 1) ? 2'b10 : 2'b01);
                end
                if ((cyc - hs_cyc) > 20) begin
                    inflight = 1'b0;
                    sb.delete();
                end
            end

            hs = bus.req_valid & bus.req_ready;
            if (hs != 2'b00) begin
                if (hs[1]) begin
                    sb.push_back(model(1, int'(bus.req1_a), int'(bus.req1_b), int'(bus.req1_op)));
                    prev_winner = 1;
                end else begin
                    sb.push_back(model(0, int'(bus.req0_a), int'(bus.req0_b), int'(bus.req0_op)));
                    prev_winner = 0;
                end
                inflight = 1'b1;
                hs_cyc   = cyc;
            end
        end

        if (drain_to_cnt != drain_seen) begin
            chk("drain_timeout", drain_to_cnt, drain_seen);
            drain_seen = drain_to_cnt;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drain();
        int n;
        n = 0;
        @(posedge clk);
        while ((q0.size() != 0 || q1.size() != 0 || v0 || v1 || inflight) && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (n >= 400) drain_to_cnt++;
        #1;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.rsp_valid == 2'b00 && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rrdy  = 2'b00;
        drain_to_cnt = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // port 0 ADD, response accepted immediately
        rrdy = 2'b11;
        @(negedge clk);
        q0.push_back('{4'b0101, 4'b0010, OP_ADD});
        drain();

        // port 1 ADD overflow, response held; port 0 waits meanwhile
        rrdy = 2'b00;
        @(negedge clk);
        q1.push_back('{4'b1111, 4'b0001, OP_ADD});
        wait_rsp();
        q0.push_back('{4'b0011, 4'b0110, OP_AND});
        repeat (2) @(posedge clk);
        #1 rrdy = 2'b01;
        repeat (2) @(posedge clk);
        #1 rrdy = 2'b10;
        @(posedge clk);
        #1 rrdy = 2'b11;
        drain();

        // both ports continuously valid
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{4'b1000, 4'b0011, OP_SUB});
            q1.push_back('{4'b1100, 4'b1010, OP_XOR});
        end
        drain();

        // illegal opcodes followed by a legal zero-result SUB
        @(negedge clk);
        q0.push_back('{4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'b110});
        q0.push_back('{4'b0110, 4'b0110, OP_SUB});
        q1.push_back('{4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'b111});
        drain();

        // NOT ignores B
        @(negedge clk);
        q0.push_back('{4'b1111, 4'($urandom_range(0, 15)), OP_NOT});
        q1.push_back('{4'b0101, 4'($urandom_range(0, 15)), OP_NOT});
        drain();

        // reset while a response is pending, then a tie
        rrdy = 2'b00;
        @(negedge clk);
        q0.push_back('{4'b0011, 4'b0100, OP_ADD});
        wait_rsp();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        rrdy = 2'b11;
        @(negedge clk);
        q0.push_back('{4'b0001, 4'b0010, OP_OR});
        q1.push_back('{4'b0100, 4'b0101, OP_ADD});
        drain();

        // randomized traffic with random response back-pressure
        repeat (300) begin
            @(posedge clk);
            #1 rrdy = 2'($urandom_range(0, 3));
            @(negedge clk);
            if (q0.size() < 2 && $urandom_range(0, 2) != 0) q0.push_back(rand_cmd());
            if (q1.size() < 2 && $urandom_range(0, 2) != 0) q1.push_back(rand_cmd());
        end
        @(posedge clk);
        #1 rrdy = 2'b11;
        drain();

        @(negedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_4bit_arbiter.md
# alu_4bit_arbiter

Shares one `alu_4bit` instance between two independent requesters. Each requester issues operand/opcode commands over a valid/ready handshake, and the block picks one winner per transaction (round-robin or fixed priority). It applies the operands to the ALU, registers Result/CarryOut/ZeroFlag and returns them to the winning port over a response handshake. The block sits between the ALU datapath and its clients, and is the only block that drives the ALU inputs.

## Interface
Parameters:
- `DATA_W`, 4: operand and result width; only 4 is legal, matching `alu_4bit`.
- `OP_W`, 3: opcode width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous assert, active-low reset.
- `req_valid`  in  2  per-port command valid; bit i belongs to port i.
- `req_ready`  out  2  per-port command accept; at most one bit high.
- `req0_a`, `req0_b`  in  DATA_W  port 0 operands.
- `req0_op`  in  OP_W  port 0 opcode.
- `req1_a`, `req1_b`  in  DATA_W  port 1 operands.
- `req1_op`  in  OP_W  port 1 opcode.
- `rsp_valid`  out  2  one-hot response valid; the bit selects the destination port.
- `rsp_ready`  in  2  per-port response accept.
- `rsp_result`  out  DATA_W  registered ALU Result.
- `rsp_carry`  out  1  registered CarryOut (borrow for SUB).
- `rsp_zero`  out  1  registered ZeroFlag.
- `rsp_err`  out  1  opcode was 3'b110 or 3'b111.

## Operation
Opcodes:
- ADD=000, SUB=001, AND=010, OR=011, XOR=100, NOT=101 (NOT ignores B).
- 110 and 111 are illegal.

FSM states are IDLE, EXEC and RESP.
- IDLE:
  - Arbitrate among the asserted `req_valid` bits. Raise `req_ready` for the winner only.
  - On handshake, latch a, b, op and the port id, update `last_grant`, and go to EXEC.
  - If no request is valid, stay in IDLE.
- EXEC:
  - Drive the ALU from the latched operands.
  - Capture Result, CarryOut and ZeroFlag into the response registers.
  - Illegal op: do not use the ALU output. Capture result=0000, carry=0, zero=1, err=1.
  - Go to RESP.
- RESP:
  - Hold `rsp_valid[id]=1` and keep the response fields stable.
  - When `rsp_ready[id]=1`, return to IDLE.
  - `rsp_ready` of the other port is ignored.

Arbitration:
- Round-robin: when both ports are valid, grant the port that is not `last_grant`. A single valid port always wins.
- `req_ready` is low in EXEC and RESP. Only one transaction is in flight at a time.
- Requesters must hold `req_valid` and their operands stable until `req_ready`. Dropping valid early is a protocol violation; the bench flags it.

Reset:
- Asserting `rst_n` low at any point forces IDLE and clears `last_grant` to 1, so port 0 wins the first tie.
- A pending response is discarded.
- All outputs reset to 0: `req_ready`, `rsp_valid`, `rsp_result`, `rsp_carry`, `rsp_zero`, `rsp_err`.

## Timing
- The command handshake happens in cycle N. EXEC is N+1. `rsp_valid` is high from N+2.
- Minimum response latency is 2 cycles. If `rsp_ready` is already high, the response completes in cycle N+2.
- Back-to-back throughput is one transaction per 3 cycles; the next handshake can occur in N+3 at the earliest.
- `req_ready` is combinational from `req_valid` and the state; it never depends on `rsp_ready`.
- Response fields change only on the EXEC→RESP transition.

## Configuration
The macro `ALU_ARB_RR_EN` selects the arbitration policy.
- Defined: round-robin arbitration as described in Operation.
- Undefined: fixed priority, where port 0 always wins ties. `last_grant` is not implemented and port 1 can starve.

## Structure
- Shared package `alu_4bit_pkg` holds:
  - opcode localparams `OP_ADD` … `OP_NOT`,
  - the state enum `arb_state_t` (IDLE/EXEC/RESP),
  - a response struct with result, carry, zero and err fields.
- Sub-module `alu_rr_arb2` is the 2-way arbiter. Its inputs are valid[1:0] and last_grant; its outputs are a one-hot grant plus grant_id. It is pure combinational, and the `ALU_ARB_RR_EN` switch lives inside it.
- `alu_4bit` is instantiated once, unmodified.

## Test plan
- Port 0 only, A=0101, B=0010, op=ADD, `rsp_ready` tied high → `rsp_valid`=01 at N+2 with result=0111, carry=0, zero=0.
- Port 1, A=1111, B=0001, ADD, with `rsp_ready[1]` held low for 4 cycles → the response holds result=0000, carry=1, zero=1 stable until accepted; `req_ready` stays 00 throughout.
- Both ports valid continuously, port 0 SUB 1000-0011, port 1 XOR 1100^1010 → grants alternate 0,1,0,1; results 0101 and 0110. With the macro undefined, every grant goes to port 0.
- Port 0 op=110 → result=0000, zero=1, err=1. The next legal op (A=0110, B=0110, SUB) → result=0000, zero=1, err=0.
- Assert `rst_n` low while in RESP → all outputs are 0 immediately. After release, a tie grants port 0 first.
- Port 0 NOT A=1111 with B=xxxx → result=0000, zero=1, carry=0.
